// File: rtl/backend_cmd_pkg.sv
// Shared command codes and frame geometry for the backend serial command lanes.
// Latency: n/a. Backpressure: n/a. BACKEND_CMD_PARITY_EN adds a trailing even-parity bit.
package backend_cmd_pkg;

   localparam logic [3:0] CMD_IDLE = 4'b1010;
   localparam logic [3:0] CMD_RST  = 4'b1100;

   function automatic int frame_len(input int code_bits);
`ifdef BACKEND_CMD_PARITY_EN
      return code_bits + 1;
`else
      return code_bits;
`endif
   endfunction

endpackage

// File: rtl/backend_cmd_ser.sv
// One serial lane: parallel load on the frame boundary, then shift out MSB first.
// Latency: loaded MSB appears on ser the cycle after load. Backpressure: none, free-running.
module backend_cmd_ser #(
   parameter int          W       = 4,
   parameter logic [W-1:0] RST_DAT = '0
) (
   input  logic         clk_100,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_dat,
   output logic         ser
);

   logic [W-1:0] sr;

   always_ff @(posedge clk_100 or negedge rst_n) begin
      if (!rst_n) begin
         sr <= RST_DAT;
      end else if (load) begin
         sr <= load_dat;
      end else begin
         sr <= {sr[W-2:0], 1'b0};
      end
   end

   assign ser = sr[W-1];

endmodule

// File: rtl/backend_cmd_tx.sv
// Drives NBACKEND serial command lanes with gap-free MSB-first frames; unaddressed lanes carry IDLE_CODE.
// Latency: a command's first bit reaches m_ser within FRAME_LEN+1 cycles of acceptance; m_ser is flop-driven.
// Backpressure: one-deep holding register, cmd_ready low while occupied. Parity option: BACKEND_CMD_PARITY_EN.
module backend_cmd_tx
   import backend_cmd_pkg::*;
#(
   parameter int                   NBACKEND  = 4,
   parameter int                   CODE_BITS = 4,
   parameter logic [CODE_BITS-1:0] IDLE_CODE = CODE_BITS'(CMD_IDLE)
) (
   input  logic                 clk_100,
   input  logic                 rst_n,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [CODE_BITS-1:0] cmd_code,
   input  logic [NBACKEND-1:0]  cmd_mask,
   output logic                 cmd_done,
   output logic                 frame_start,
   output logic [NBACKEND-1:0]  m_ser
);

   localparam int FRAME_LEN = frame_len(CODE_BITS);
   localparam int CW        = $clog2(FRAME_LEN);

   typedef struct packed {
      logic [CODE_BITS-1:0] code;
      logic [NBACKEND-1:0]  mask;
   } cmd_t;

   function automatic logic [FRAME_LEN-1:0] mk_frame(input logic [CODE_BITS-1:0] c);
`ifdef BACKEND_CMD_PARITY_EN
      return {c, ^c};
`else
      return c;
`endif
   endfunction

   localparam logic [FRAME_LEN-1:0] IDLE_FRAME = mk_frame(IDLE_CODE);

   logic [CW-1:0]        cnt;
   logic                 boundary;
   logic                 pend_vld;
   cmd_t                 pend_dat;
   logic                 frm_is_cmd;
   logic [FRAME_LEN-1:0] cmd_frame;

   assign boundary  = (cnt == CW'(FRAME_LEN - 1));
   assign cmd_frame = mk_frame(pend_dat.code);

   always_ff @(posedge clk_100 or negedge rst_n) begin
      if (!rst_n) begin
         cnt        <= '0;
         pend_vld   <= 1'b0;
         pend_dat   <= '0;
         frm_is_cmd <= 1'b0;
      end else begin
         cnt <= boundary ? '0 : cnt + 1'b1;
         if (boundary) begin
            frm_is_cmd <= pend_vld;
         end
         // Clearing and accepting are exclusive because cmd_ready is ~pend_vld.
         if (boundary && pend_vld) begin
            pend_vld <= 1'b0;
         end else if (cmd_valid && cmd_ready) begin
            pend_vld      <= 1'b1;
            pend_dat.code <= cmd_code;
            pend_dat.mask <= cmd_mask;
         end
      end
   end

   // rst_n gating keeps these low throughout reset while the counter sits at 0.
   assign cmd_ready   = rst_n & ~pend_vld;
   assign frame_start = rst_n & (cnt == '0);
   assign cmd_done    = boundary & frm_is_cmd;

   for (genvar i = 0; i < NBACKEND; i++) begin : g_lane
      logic [FRAME_LEN-1:0] load_dat;

      assign load_dat = (pend_vld && pend_dat.mask[i]) ? cmd_frame : IDLE_FRAME;

      backend_cmd_ser #(
         .W       (FRAME_LEN),
         .RST_DAT (IDLE_FRAME)
      ) u_ser (
         .clk_100  (clk_100),
         .rst_n    (rst_n),
         .load     (boundary),
         .load_dat (load_dat),
         .ser      (m_ser[i])
      );
   end

endmodule

// File: tb/tb_backend_cmd_tx.sv
// Self-checking bench for backend_cmd_tx: frame-level reference model checked every cycle,
// a table of single-command vectors, and hand-written back-to-back and reset sequences.
module tb_backend_cmd_tx;

   localparam int            NB   = 4;
   localparam int            CB   = 4;
   localparam logic [CB-1:0] IDLE = 4'b1010;
`ifdef BACKEND_CMD_PARITY_EN
   localparam int L = CB + 1;
`else
   localparam int L = CB;
`endif

   logic          clk_100 = 1'b0;
   logic          rst_n = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [CB-1:0] cmd_code = '0;
   logic [NB-1:0] cmd_mask = '0;
   logic          cmd_done;
   logic          frame_start;
   logic [NB-1:0] m_ser;

   int n_checks = 0;
   int n_errors = 0;

   backend_cmd_tx #(
      .NBACKEND  (NB),
      .CODE_BITS (CB),
      .IDLE_CODE (IDLE)
   ) dut (
      .clk_100     (clk_100),
      .rst_n       (rst_n),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_code    (cmd_code),
      .cmd_mask    (cmd_mask),
      .cmd_done    (cmd_done),
      .frame_start (frame_start),
      .m_ser       (m_ser)
   );

   always #5 clk_100 = ~clk_100;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         if (n_errors <= 30)
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Frame sent on the wire for a code: code bits, then an even-parity bit when enabled.
   function automatic logic [L-1:0] wire_frame(input logic [CB-1:0] c);
`ifdef BACKEND_CMD_PARITY_EN
      return {c, 1'($countones(c) % 2)};
`else
      return c;
`endif
   endfunction

   // Reference model: cycle t after reset release lies in frame t/L at bit t%L. An accepted
   // command owns the first frame starting at least two cycles after its acceptance cycle.
   logic [CB-1:0] frm_code [int];
   logic [NB-1:0] frm_mask [int];
   int            m_t = 0;
   int            m_ready_at = 0;
   int            m_f, m_p, m_s;
   logic          m_rdy, m_done, m_fs;
   logic [NB-1:0] m_ser_exp;
   logic [L-1:0]  m_lf;

   always @(negedge clk_100) begin
      if (!rst_n) begin
         check("reset_outputs", 64'({m_ser, cmd_ready, cmd_done, frame_start}),
               64'({{NB{IDLE[CB-1]}}, 3'b000}));
         m_t = 0;
         m_ready_at = 0;
         frm_code.delete();
         frm_mask.delete();
      end else begin
         m_f = m_t / L;
         m_p = m_t % L;
         for (int i = 0; i < NB; i++) begin
            if (frm_code.exists(m_f) && frm_mask[m_f][i]) m_lf = wire_frame(frm_code[m_f]);
            else                                         m_lf = wire_frame(IDLE);
            m_ser_exp[i] = m_lf[L-1-m_p];
         end
         m_rdy  = (m_t >= m_ready_at);
         m_done = (m_p == L - 1) && frm_code.exists(m_f);
         m_fs   = (m_p == 0);
         check("model_cycle {m_ser,ready,done,fstart}",
               64'({m_ser, cmd_ready, cmd_done, frame_start}),
               64'({m_ser_exp, m_rdy, m_done, m_fs}));
         if (cmd_valid && m_rdy) begin
            m_s = ((m_t + 2 + L - 1) / L) * L;
            frm_code[m_s / L] = cmd_code;
            frm_mask[m_s / L] = cmd_mask;
            m_ready_at = m_s;
         end
         m_t++;
      end
   end

   task automatic send(input logic [CB-1:0] c, input logic [NB-1:0] m);
      bit ok = 0;
      int n = 0;
      @(posedge clk_100); #1;
      cmd_valid = 1'b1; cmd_code = c; cmd_mask = m;
      while (!ok && n < 4 * L) begin
         @(negedge clk_100);
         if (cmd_ready) ok = 1;
         n++;
      end
      @(posedge clk_100); #1;
      cmd_valid = 1'b0; cmd_code = CB'($urandom); cmd_mask = NB'($urandom);
      if (!ok) check("send_accept_timeout", 64'(0), 64'(1));
   endtask

   task automatic count_pulses(input int cycles, output int n_fs, output int n_done);
      n_fs = 0; n_done = 0;
      for (int k = 0; k < cycles; k++) begin
         @(negedge clk_100);
         if (frame_start) n_fs++;
         if (cmd_done) n_done++;
      end
   endtask

   typedef struct {
      logic [CB-1:0]    code;
      logic [NB-1:0]    mask;
      logic [NB*CB-1:0] lanes;   // expected code per lane, lane 3 in the top nibble
   } vec_t;

   vec_t vecs[7];

   initial begin
      int           n_fs, n_done, n, d0, d1, acc;
      bit           got, take;
      logic [L-1:0] hist [NB];
      logic [63:0]  act_pk, exp_pk;

      vecs[0] = '{4'b1100, 4'b0101, 16'b1010_1100_1010_1100};
      vecs[1] = '{4'b1100, 4'b0000, 16'b1010_1010_1010_1010};
      vecs[2] = '{4'b1010, 4'b1111, 16'b1010_1010_1010_1010};
      vecs[3] = '{4'b0011, 4'b1000, 16'b0011_1010_1010_1010};
      vecs[4] = '{4'b0110, 4'b1111, 16'b0110_0110_0110_0110};
      vecs[5] = '{4'b1111, 4'b0010, 16'b1010_1010_1111_1010};
      vecs[6] = '{4'b0000, 4'b0110, 16'b1010_0000_0000_1010};

      // Reset held, then released away from the clock edge.
      repeat (3) @(posedge clk_100);
      #1 rst_n = 1'b1;

      // Idle stream: one frame_start per frame, never a cmd_done.
      count_pulses(4 * L, n_fs, n_done);
      check("idle_frame_starts", 64'(n_fs), 64'(4));
      check("idle_no_done", 64'(n_done), 64'(0));

      // Single commands: capture each lane's command frame ending at cmd_done.
      foreach (vecs[v]) begin
         send(vecs[v].code, vecs[v].mask);
         got = 0; n = 0;
         while (!got && n < 3 * L) begin
            @(negedge clk_100);
            for (int i = 0; i < NB; i++) hist[i] = {hist[i][L-2:0], m_ser[i]};
            if (cmd_done) got = 1;
            n++;
         end
         act_pk = '0; exp_pk = '0;
         for (int i = NB - 1; i >= 0; i--) begin
            act_pk = (act_pk << L) | 64'(hist[i]);
            exp_pk = (exp_pk << L) | 64'(wire_frame(vecs[v].lanes[i*CB +: CB]));
         end
         check($sformatf("vec%0d_done_seen", v), 64'(got), 64'(1));
         check($sformatf("vec%0d_lane_frames", v), act_pk, exp_pk);
         count_pulses(L, n_fs, n_done);
         check($sformatf("vec%0d_no_extra_done", v), 64'(n_done), 64'(0));
      end

      // Back-to-back: second command held by the source, sent in the very next frame.
      acc = 0; n_done = 0; d0 = 0; d1 = 0; n = 0;
      @(posedge clk_100); #1;
      cmd_valid = 1'b1; cmd_code = 4'b1100; cmd_mask = 4'b0011;
      while (n_done < 2 && n < 6 * L) begin
         @(negedge clk_100);
         n++;
         if (cmd_done) begin
            if (n_done == 0) d0 = n; else d1 = n;
            n_done++;
         end
         take = cmd_valid && cmd_ready;
         @(posedge clk_100); #1;
         if (take) begin
            acc++;
            if (acc == 1) begin cmd_code = 4'b0101; cmd_mask = 4'b1100; end
            else cmd_valid = 1'b0;
         end
      end
      cmd_valid = 1'b0;
      check("b2b_done_count", 64'(n_done), 64'(2));
      check("b2b_done_spacing", 64'(d1 - d0), 64'(L));
      check("b2b_accepts", 64'(acc), 64'(2));

      // Reset in the middle of a command frame.
      send(4'b0000, 4'b1111);
      @(negedge clk_100);
      n = 0;
      do begin
         @(negedge clk_100);
         n++;
      end while (!frame_start && n < L + 2);
      @(posedge clk_100); #1;
      rst_n = 1'b0;
      #1 check("rst_mid_frame_mser", 64'(m_ser), 64'({NB{IDLE[CB-1]}}));
      repeat (2) @(posedge clk_100);
      #1 rst_n = 1'b1;
      count_pulses(3 * L, n_fs, n_done);
      check("post_rst_no_done", 64'(n_done), 64'(0));
      check("post_rst_frame_starts", 64'(n_fs), 64'(3));

      // Reset while a command is still pending: discarded, no cmd_done.
      send(4'b1100, 4'b1111);
      rst_n = 1'b0;
      #1 check("rst_pending_ready_low", 64'(cmd_ready), 64'(0));
      repeat (2) @(posedge clk_100);
      #1 rst_n = 1'b1;
      count_pulses(3 * L, n_fs, n_done);
      check("pending_discarded_no_done", 64'(n_done), 64'(0));

      // Randomized traffic, including code/mask churn while a command is pending.
      for (int k = 0; k < 1500; k++) begin
         @(posedge clk_100); #1;
         cmd_valid = ($urandom_range(0, 99) < 40);
         cmd_code  = CB'($urandom);
         cmd_mask  = NB'($urandom);
      end
      @(posedge clk_100); #1;
      cmd_valid = 1'b0;
      repeat (3 * L) @(posedge clk_100);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
